// File: rtl/mac_seq_pkg.sv
// Shared types and default sizes for the MAC dot-product sequencer.
package mac_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LEN_W  = 8;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_acc_stage.sv
// Product register plus accumulator with sticky carry-out flag.
// Build with MAC_SEQ_SATURATE_EN to clamp the accumulator on carry-out instead of wrapping.
module mac_acc_stage
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_fire,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic              pipe_empty
);

  localparam int ProdW = 2 * DATA_W;
  localparam int SumW  = ACC_W + 1;

  logic [ProdW-1:0] prod_q;
  logic             prod_v_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [SumW-1:0]  sum;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    sum   = {1'b0, acc_q} + SumW'(prod_q);
    acc_d = sum[ACC_W-1:0];
    ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC_SEQ_SATURATE_EN
    // Once saturated the accumulator stays pinned until the next clear.
    if (ovf_d) acc_d = '1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prod_v_q <= in_fire;
      if (in_fire) prod_q <= ProdW'(a) * ProdW'(b);
      if (prod_v_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign acc        = acc_q;
  assign ovf        = ovf_q;
  assign pipe_empty = ~prod_v_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Clear/run/drain/hold sequencer for an unsigned multiply-accumulate dot product.
// MAC_SEQ_SATURATE_EN (in mac_acc_stage) selects saturating instead of wrapping accumulation.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);

  seq_state_e       state_q;
  logic [LEN_W-1:0] rem_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  logic             clr;
  logic             in_fire;
  logic             pipe_empty;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  assign clr     = (state_q == IDLE) && start;
  assign in_fire = in_valid && in_ready_q;

  mac_acc_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_fire    (in_fire),
    .a          (a),
    .b          (b),
    .acc        (acc),
    .ovf        (ovf),
    .pipe_empty (pipe_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= LOAD;
              rem_q      <= len;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= HOLD;
              res_valid_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // The last product still sits in stage 1 on entry; wait for it to land in acc.
        DRAIN: begin
          if (pipe_empty) begin
            state_q     <= HOLD;
            res_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // acc only moves between a start and the following HOLD, so it doubles as the held result.
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc;
  assign res_ovf   = ovf;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed plus randomized bench for mac_dot_sequencer against a plain-arithmetic dot-product model.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] pa [256];
  logic [15:0] pb [256];

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact dot product in 64 bits, then reduced to what a 32-bit accumulator must report.
  function automatic void model(input int n, output logic [31:0] d, output logic o);
    longint unsigned s = 0;
    for (int i = 0; i < n; i++) s += 64'(pa[i]) * 64'(pb[i]);
    o = (s > 64'h0000_0000_FFFF_FFFF);
`ifdef MAC_SEQ_SATURATE_EN
    d = o ? 32'hFFFF_FFFF : s[31:0];
`else
    d = s[31:0];
`endif
  endfunction

  task automatic load_random(input int n, input bit big);
    for (int i = 0; i < n; i++) begin
      pa[i] = big ? 16'($urandom_range(16'hFFFF, 16'hC000)) : 16'($urandom);
      pb[i] = big ? 16'($urandom_range(16'hFFFF, 16'hC000)) : 16'($urandom);
    end
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    len   = 8'($urandom);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic feed(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      int w;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        step();
      end
      in_valid = 1'b1;
      a = pa[i];
      b = pb[i];
      w = 0;
      while (!in_ready && w < 20) begin
        step();
        w++;
      end
      check("in_ready_before_pair", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Called just after the final handshake edge; result must appear on the second edge after it.
  task automatic expect_latency();
    check("lat_edge0_valid", res_valid, 1'b0);
    check("lat_drain_in_ready", in_ready, 1'b0);
    step();
    check("lat_edge1_valid", res_valid, 1'b0);
    step();
    check("lat_edge2_valid", res_valid, 1'b1);
  endtask

  task automatic check_result(input int n);
    logic [31:0] d;
    logic        o;
    model(n, d, o);
    check("result_data", res_data, d);
    check("result_ovf", res_ovf, o);
    check("result_busy", busy, 1'b1);
  endtask

  task automatic release_result(input int hold, input bit poke_start, input bit restart, input int next_len);
    logic [31:0] d0;
    logic        o0;
    d0 = res_data;
    o0 = res_ovf;
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      if (poke_start) begin
        start = 1'($urandom_range(1, 0));
        len   = 8'($urandom);
      end
      step();
      check("hold_valid", res_valid, 1'b1);
      check("hold_data", res_data, d0);
      check("hold_ovf", res_ovf, o0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    if (restart) begin
      start = 1'b1;
      len   = 8'(next_len);
    end
    step();
    res_ready = 1'b0;
    check("release_valid_drop", res_valid, 1'b0);
    check("release_not_busy", busy, 1'b0);
    check("release_data_kept", res_data, d0);
    check("release_ovf_kept", res_ovf, o0);
    if (restart) begin
      step();
      start = 1'b0;
      len   = 8'($urandom);
      check("restart_accepted", busy, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_ovf", res_ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic job, back-to-back pairs
    pa[0] = 16'd1; pb[0] = 16'd5;
    pa[1] = 16'd2; pb[1] = 16'd6;
    pa[2] = 16'd3; pb[2] = 16'd7;
    pa[3] = 16'd4; pb[3] = 16'd8;
    start_job(4);
    feed(4, 0);
    expect_latency();
    check("basic_data", res_data, 32'h0000_0046);
    check("basic_ovf", res_ovf, 1'b0);
    release_result(1, 1'b0, 1'b0, 0);

    // Zero length goes straight to a zero result
    in_valid = 1'b1;
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    check("zero_in_ready", in_ready, 1'b0);
    check("zero_valid", res_valid, 1'b1);
    check("zero_data", res_data, 32'h0);
    check("zero_ovf", res_ovf, 1'b0);
    in_valid = 1'b0;
    release_result(2, 1'b0, 1'b0, 0);

    // Input stalls and result backpressure with start pokes in HOLD
    load_random(3, 1'b0);
    start_job(3);
    feed(3, 3);
    expect_latency();
    check_result(3);
    release_result(10, 1'b1, 1'b0, 0);

    // Overflow, then a back-to-back job that must clear the flag
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF;
    pa[1] = 16'hFFFF; pb[1] = 16'hFFFF;
    start_job(2);
    feed(2, 0);
    expect_latency();
`ifdef MAC_SEQ_SATURATE_EN
    check("ovf_data", res_data, 32'hFFFF_FFFF);
`else
    check("ovf_data", res_data, 32'hFFFC_0002);
`endif
    check("ovf_flag", res_ovf, 1'b1);
    pa[0] = 16'd10; pb[0] = 16'd20;
    pa[1] = 16'd30; pb[1] = 16'd40;
    release_result(2, 1'b0, 1'b1, 2);
    feed(2, 0);
    expect_latency();
    check("b2b_data", res_data, 32'd1400);
    check("b2b_ovf", res_ovf, 1'b0);
    release_result(1, 1'b0, 1'b0, 0);

    // Reset in the middle of a job
    for (int i = 0; i < 5; i++) begin
      pa[i] = 16'($urandom) | 16'h1;
      pb[i] = 16'($urandom) | 16'h1;
    end
    start_job(5);
    feed(2, 0);
    step();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_valid", res_valid, 1'b0);
    check("midrst_data", res_data, 32'h0);
    check("midrst_ovf", res_ovf, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    pa[0] = 16'd3; pb[0] = 16'd3;
    start_job(1);
    feed(1, 0);
    expect_latency();
    check("post_rst_data", res_data, 32'd9);
    check("post_rst_ovf", res_ovf, 1'b0);
    release_result(1, 1'b0, 1'b0, 0);

    // Randomized jobs against the model
    for (int j = 0; j < 10; j++) begin
      int n;
      n = int'($urandom_range(12, 0));
      load_random(n, (j % 2) == 1);
      if (n == 0) begin
        start = 1'b1;
        len   = 8'd0;
        step();
        start = 1'b0;
        check("rand_zero_valid", res_valid, 1'b1);
        check_result(0);
      end else begin
        start_job(n);
        feed(n, j % 3);
        expect_latency();
        check_result(n);
      end
      release_result((j % 4) + 1, (j % 2) == 0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
